// File: rtl/tcm_dump_streamer.sv
// Reads a block of 32-bit words from a TCM read port and streams them out
// LSB-first as bytes on a valid/ready interface.
module tcm_dump_streamer #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_cnt,
    output logic              busy,
    output logic              done,
    output logic              ram_cs,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_rdata,
    output logic              byte_vld,
    input  logic              byte_rdy,
    output logic [7:0]        byte_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_SEND,
        S_FIN
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [ADDR_W-1:0]   hold_addr_reg, hold_addr_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [1:0]          idx_reg, idx_next;
    logic [31:0]         shift_reg, shift_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            hold_addr_reg <= '0;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            shift_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            hold_addr_reg <= hold_addr_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            shift_reg     <= shift_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        hold_addr_next = hold_addr_reg;
        cnt_next       = cnt_reg;
        idx_next       = idx_reg;
        shift_next     = shift_reg;
        ram_cs         = 1'b0;
        byte_vld       = 1'b0;
        done           = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    addr_next  = base_addr;
                    cnt_next   = word_cnt;
                    idx_next   = 2'd0;
                    state_next = (word_cnt == '0) ? S_FIN : S_RD;
                end
            end
            S_RD: begin
                ram_cs         = 1'b1;
                hold_addr_next = addr_reg;
                state_next     = S_WAIT;
            end
            S_WAIT: begin
                shift_next = ram_rdata;
                state_next = S_SEND;
            end
            S_SEND: begin
                byte_vld = 1'b1;
                if (byte_rdy) begin
                    shift_next = {8'h00, shift_reg[31:8]};
                    idx_next   = idx_reg + 2'd1;
                    // Word finished after its fourth byte leaves.
                    if (idx_reg == 2'd3) begin
                        cnt_next = cnt_reg - CNT_W'(1);
                        if (cnt_reg == CNT_W'(1)) begin
                            state_next = S_FIN;
                        end else begin
                            addr_next  = addr_reg + ADDR_W'(1);
                            state_next = S_RD;
                        end
                    end
                end
            end
            S_FIN: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Address is presented only during the strobe; otherwise the last issued one is held.
    assign ram_addr  = (state_reg == S_RD) ? addr_reg : hold_addr_reg;
    assign busy      = (state_reg != S_IDLE);
    assign byte_data = (state_reg == S_SEND) ? shift_reg[7:0] : 8'h00;

endmodule

// File: tb/tb_tcm_dump_streamer.sv
// Directed bench for tcm_dump_streamer: TCM model with registered read,
// negedge monitor collecting strobes and transferred bytes.
module tb_tcm_dump_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] word_cnt;
    logic        busy, done, ram_cs, byte_vld, byte_rdy;
    logic [11:0] ram_addr;
    logic [31:0] ram_rdata;
    logic [7:0]  byte_data;

    logic [31:0] mem [0:4095];
    logic [7:0]  bytes_q[$];
    logic [11:0] cs_q[$];
    int          done_cnt, vld_cnt, stall_err;
    int          compared, mismatched;
    logic        prev_vld, prev_rdy;
    logic [7:0]  prev_data;

    tcm_dump_streamer #(.ADDR_W(12), .CNT_W(13)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_cnt(word_cnt), .busy(busy), .done(done), .ram_cs(ram_cs),
        .ram_addr(ram_addr), .ram_rdata(ram_rdata), .byte_vld(byte_vld),
        .byte_rdy(byte_rdy), .byte_data(byte_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs) ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_cs) cs_q.push_back(ram_addr);
            if (byte_vld) vld_cnt++;
            if (byte_vld && byte_rdy) bytes_q.push_back(byte_data);
            if (done) done_cnt++;
            if (prev_vld && !prev_rdy && (!byte_vld || byte_data !== prev_data)) stall_err++;
        end
        prev_vld  = byte_vld && rst_n;
        prev_rdy  = byte_rdy;
        prev_data = byte_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        bytes_q.delete();
        cs_q.delete();
        done_cnt  = 0;
        vld_cnt   = 0;
        stall_err = 0;
    endtask

    task automatic chk_bytes(input string tag, input logic [31:0] words[$]);
        logic [7:0] obs;
        chk({tag, "_nbytes"}, bytes_q.size(), 4 * words.size());
        for (int i = 0; i < 4 * words.size(); i++) begin
            obs = (i < bytes_q.size()) ? bytes_q[i] : 8'hxx;
            chk($sformatf("%s_byte%0d", tag, i), {24'h0, obs}, {24'h0, words[i/4][(i%4)*8 +: 8]});
        end
    endtask

    task automatic chk_addrs(input string tag, input logic [11:0] addrs[$]);
        logic [11:0] obs;
        chk({tag, "_ncs"}, cs_q.size(), addrs.size());
        for (int i = 0; i < addrs.size(); i++) begin
            obs = (i < cs_q.size()) ? cs_q[i] : 12'hxxx;
            chk($sformatf("%s_addr%0d", tag, i), {20'h0, obs}, {20'h0, addrs[i]});
        end
    endtask

    task automatic kick(input logic [11:0] b, input logic [12:0] c);
        start     = 1'b1;
        base_addr = b;
        word_cnt  = c;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input bit toggle_rdy);
        logic [3:0] pat;
        int n;
        pat = 4'b1001;
        n = 0;
        while (done_cnt == 0 && n < 500) begin
            if (toggle_rdy) byte_rdy = pat[3 - (n % 4)];
            step();
            n++;
        end
        byte_rdy = 1'b1;
        chk({tag, "_done_seen"}, (done_cnt != 0), 1);
        repeat (3) step();
    endtask

    initial begin
        logic [31:0] w[$];
        logic [11:0] a[$];
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        compared = 0; mismatched = 0;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0; byte_rdy = 1'b1;
        clear_mon();
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", ram_cs, 0);
        chk("rst_vld", byte_vld, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_data", byte_data, 0);
        rst_n = 1'b1;
        step();

        // Single word, exact cycle timing
        mem[12'h020] = 32'h1234_5678;
        clear_mon();
        kick(12'h020, 13'd1);
        chk("t1_k1_cs", ram_cs, 1);
        chk("t1_k1_addr", ram_addr, 12'h020);
        chk("t1_k1_busy", busy, 1);
        step();
        chk("t1_k2_cs", ram_cs, 0);
        chk("t1_k2_vld", byte_vld, 0);
        chk("t1_k2_addr", ram_addr, 12'h020);
        step();
        chk("t1_k3_vld", byte_vld, 1);
        chk("t1_k3_data", byte_data, 8'h78);
        step(); chk("t1_k4_data", byte_data, 8'h56);
        step(); chk("t1_k5_data", byte_data, 8'h34);
        step(); chk("t1_k6_data", byte_data, 8'h12);
        chk("t1_k6_vld", byte_vld, 1);
        step();
        chk("t1_k7_done", done, 1);
        chk("t1_k7_vld", byte_vld, 0);
        chk("t1_k7_busy", busy, 1);
        step();
        chk("t1_k8_done", done, 0);
        chk("t1_k8_busy", busy, 0);
        w = {32'h1234_5678}; chk_bytes("t1", w);
        a = {12'h020}; chk_addrs("t1", a);
        chk("t1_ndone", done_cnt, 1);

        // Multi-word with backpressure
        for (int i = 0; i < 3; i++) mem[i] = 32'h0000_0001;
        clear_mon();
        kick(12'h000, 13'd3);
        run_until_done("t2", 1'b1);
        w = {32'h1, 32'h1, 32'h1}; chk_bytes("t2", w);
        a = {12'h000, 12'h001, 12'h002}; chk_addrs("t2", a);
        chk("t2_stall_stable", stall_err, 0);
        chk("t2_ndone", done_cnt, 1);

        // Zero count
        clear_mon();
        kick(12'h055, 13'd0);
        chk("t3_k1_done", done, 1);
        chk("t3_k1_busy", busy, 1);
        chk("t3_k1_cs", ram_cs, 0);
        step();
        chk("t3_k2_done", done, 0);
        chk("t3_k2_busy", busy, 0);
        repeat (3) step();
        chk("t3_ncs", cs_q.size(), 0);
        chk("t3_nvld", vld_cnt, 0);
        chk("t3_ndone", done_cnt, 1);

        // Address wrap
        mem[12'hFFF] = 32'hA1B2_C3D4;
        mem[12'h000] = 32'h1122_3344;
        clear_mon();
        kick(12'hFFF, 13'd2);
        run_until_done("t4", 1'b0);
        w = {32'hA1B2_C3D4, 32'h1122_3344}; chk_bytes("t4", w);
        a = {12'hFFF, 12'h000}; chk_addrs("t4", a);

        // Reset mid-dump, during 2nd byte of the second word
        for (int i = 0; i < 4; i++) mem[12'h100 + i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        mem[12'h200] = 32'hCAFE_F00D;
        clear_mon();
        kick(12'h100, 13'd4);
        repeat (8) step();
        chk("t5_w1b0", byte_data, 8'h04);
        step();
        chk("t5_w1b1_vld", byte_vld, 1);
        chk("t5_w1b1", byte_data, 8'h05);
        rst_n = 1'b0;
        start = 1'b1; base_addr = 12'h300; word_cnt = 13'd1;
        step();
        rst_n = 1'b1;
        start = 1'b0;
        chk("t5_rst_vld", byte_vld, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_cs", ram_cs, 0);
        chk("t5_rst_done", done, 0);
        step();
        chk("t5_start_in_rst_ignored", busy, 0);
        clear_mon();
        kick(12'h200, 13'd1);
        run_until_done("t5b", 1'b0);
        w = {32'hCAFE_F00D}; chk_bytes("t5b", w);
        a = {12'h200}; chk_addrs("t5b", a);

        // Start while busy is ignored
        mem[12'h010] = 32'h0403_0201;
        mem[12'h011] = 32'h0807_0605;
        mem[12'h040] = 32'hDEAD_BEEF;
        clear_mon();
        kick(12'h010, 13'd2);
        repeat (3) step();
        kick(12'h040, 13'd1);
        run_until_done("t6", 1'b0);
        repeat (10) step();
        w = {32'h0403_0201, 32'h0807_0605}; chk_bytes("t6", w);
        a = {12'h010, 12'h011}; chk_addrs("t6", a);
        chk("t6_ndone", done_cnt, 1);
        chk("t6_busy_end", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tcm_dump_streamer.md
Name: tcm_dump_streamer

Overview:
- Readback engine for ITCM/DTCM: reads a block of 32-bit words through a TCM SRAM read port and streams them out as bytes on a valid/ready interface.
- Bytes leave in file order, least-significant byte first. This matches the byte order used when loading program images into the TCMs, so a dump round-trips to the original image file.
- Sits beside the srams wrapper. It shares the TCM port through an external arbiter and drives a debug/host byte sink.

Parameters:
- ADDR_W, 12, TCM word-address width; addresses wrap modulo 2^ADDR_W.
- CNT_W, 13, width of the word-count input (ADDR_W+1 so a full-depth dump is expressible).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request a dump; sampled only in IDLE
- base_addr  input  ADDR_W  first word address; sampled with start
- word_cnt  input  CNT_W  number of words to dump; sampled with start
- busy  output  1  high from the cycle after start is accepted until the done cycle, inclusive
- done  output  1  one-cycle pulse at end of dump
- ram_cs  output  1  TCM read strobe
- ram_addr  output  ADDR_W  TCM word address
- ram_rdata  input  32  TCM read data, valid the cycle after ram_cs
- byte_vld  output  1  output byte valid
- byte_rdy  input  1  sink ready
- byte_data  output  8  output byte

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs go to 0 and the FSM goes to IDLE, including mid-dump.
  - No further ram_cs is issued.
  - A byte pending on the interface is dropped with no handshake.
- FSM states: IDLE, RD, WAIT, SEND, FIN.
- IDLE:
  - If start=1 at edge k: latch base_addr into the address register, latch word_cnt into the remaining-word counter, clear the byte index.
  - If word_cnt=0, go to FIN; otherwise go to RD.
- RD (one cycle): ram_cs=1, ram_addr = address register. Then go to WAIT.
- WAIT (one cycle):
  - ram_rdata is valid in this cycle; capture it into the 32-bit shift register at the end-of-cycle edge.
  - Go to SEND.
- SEND:
  - byte_vld=1 and byte_data = shift_reg[7:0].
  - byte_data must stay stable while byte_vld=1 and byte_rdy=0.
  - On an edge with byte_vld & byte_rdy: shift the register right by 8 and increment the byte index (2 bits).
  - After the 4th transfer:
    - Decrement the remaining-word counter.
    - If the counter becomes 0, go to FIN.
    - Otherwise increment the address (wraps from 2^ADDR_W-1 to 0) and go to RD.
- FIN: done=1 for exactly one cycle, then go to IDLE.
- ram_cs is 0 in every state except RD; ram_addr holds its last value when ram_cs=0.
- byte_vld is 0 outside SEND.
- busy is 1 in RD, WAIT, SEND and FIN.
- Timing (start accepted at edge k, byte_rdy tied high):
  - Cycle k+1: ram_cs.
  - Cycle k+3: first byte_vld.
  - Steady state: 6 cycles per word (RD + WAIT + 4×SEND).
- Cycle mapping for word_cnt=0: IDLE accepts start at edge k, FIN in cycle k+1, done=1 in cycle k+1, no ram_cs at any point.
- start asserted while busy is ignored and not queued.
- Byte order per word: [7:0], [15:8], [23:16], [31:24].
- A start in the same cycle as rst_n=0 is ignored.

Test Plan:
- Single word: preload TCM[0x20]=0x1234_5678, start with base=0x20, cnt=1, byte_rdy=1 -> bytes 0x78, 0x56, 0x34, 0x12 in cycles k+3..k+6; done in k+7; exactly one ram_cs, at addr 0x20.
- Multi-word with backpressure: TCM[0..2]=0x0000_0001 (DTCM init pattern), cnt=3, byte_rdy toggling 1,0,0,1 -> byte stream 01 00 00 00 repeated 3 times; byte_data stable during every stall; 3 ram_cs pulses at addrs 0, 1, 2.
- Zero count: cnt=0 -> done pulses in cycle k+1; no ram_cs, no byte_vld.
- Address wrap: base=0xFFF, cnt=2 -> ram_cs at 0xFFF then 0x000; 8 bytes emitted in order.
- Reset mid-dump: assert rst_n=0 during the 2nd byte of word 1 of a 4-word dump -> on the next edge byte_vld, busy, ram_cs and done are all 0; a new start afterwards dumps correctly from its own base.
- Start while busy: pulse start with base=0x40 during a dump from base=0x10 -> ignored; all ram_addr values stay in the 0x10 run; only one done pulse.
